// File: rtl/cordic_pkg.sv
// Shared types and the elaboration-time arctangent table generator for the
// iterative CORDIC engine.
package cordic_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_e;

    typedef enum logic {
        ROTATION  = 1'b0,
        VECTORING = 1'b1
    } mode_e;

    localparam real Pi = 3.14159265358979323846;

    // Binary angle: a full circle spans 2^width codes, so one radian is
    // 2^(width-1)/pi codes. Only ever called with constant arguments.
    function automatic int atan_lut(input int i, input int width);
        real angle;
        angle = $atan(1.0 / (2.0 ** i)) * (2.0 ** (width - 1)) / Pi;
        return $rtoi(angle + 0.5);
    endfunction

endpackage

// File: rtl/cordic_stage.sv
// One CORDIC micro-rotation: shift-and-add update of x, y and the residual
// angle z, with d_i = 1 meaning d = +1 and d_i = 0 meaning d = -1.
module cordic_stage #(
    parameter int Width = 16,
    parameter int CntW  = 4
) (
    input  logic [Width-1:0] x_i,
    input  logic [Width-1:0] y_i,
    input  logic [Width-1:0] z_i,
    input  logic [CntW-1:0]  i_i,
    input  logic             d_i,
    input  logic [Width-1:0] atan_i,
    output logic [Width-1:0] x_o,
    output logic [Width-1:0] y_o,
    output logic [Width-1:0] z_o
);

    logic signed [Width-1:0] x_sh;
    logic signed [Width-1:0] y_sh;

    assign x_sh = $signed(x_i) >>> i_i;
    assign y_sh = $signed(y_i) >>> i_i;

    assign x_o = d_i ? (x_i - y_sh)   : (x_i + y_sh);
    assign y_o = d_i ? (y_i + x_sh)   : (y_i - x_sh);
    assign z_o = d_i ? (z_i - atan_i) : (z_i + atan_i);

endmodule

// File: rtl/cordic_iter.sv
// Iterative CORDIC engine: one micro-rotation per clock, valid/ready on both
// sides, gain left uncompensated for the caller to prescale.
module cordic_iter
    import cordic_pkg::*;
#(
    parameter int Width = 16,
    parameter int Iter  = 16
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             in_valid_i,
    output logic             in_ready_o,
    input  logic             mode_i,
    input  logic [Width-1:0] x_i,
    input  logic [Width-1:0] y_i,
    input  logic [Width-1:0] z_i,
    output logic             out_valid_o,
    input  logic             out_ready_i,
    output logic [Width-1:0] x_o,
    output logic [Width-1:0] y_o,
    output logic [Width-1:0] z_o,
    output logic             busy_o
);

    localparam int              CntW  = (Iter > 1) ? $clog2(Iter) : 1;
    localparam logic [CntW-1:0] LastI = CntW'(Iter - 1);

    state_e          state_q, state_d;
    mode_e           mode_q, mode_d;
    logic [CntW-1:0] i_q, i_d;
    logic [Width-1:0] x_q, y_q, z_q;
    logic [Width-1:0] x_d, y_d, z_d;
    logic [Width-1:0] x_nx, y_nx, z_nx;
    logic [Width-1:0] atan_tbl [Iter];
    logic [Width-1:0] atan_cur;
    logic             dir;

    for (genvar g = 0; g < Iter; g++) begin : g_lut
        localparam logic [Width-1:0] Atan = Width'(atan_lut(g, Width));
        assign atan_tbl[g] = Atan;
    end

    assign atan_cur = atan_tbl[i_q];
    // Rotation drives z toward 0; vectoring drives y toward 0.
    assign dir = (mode_q == VECTORING) ? y_q[Width-1] : ~z_q[Width-1];

    cordic_stage #(
        .Width (Width),
        .CntW  (CntW)
    ) u_stage (
        .x_i    (x_q),
        .y_i    (y_q),
        .z_i    (z_q),
        .i_i    (i_q),
        .d_i    (dir),
        .atan_i (atan_cur),
        .x_o    (x_nx),
        .y_o    (y_nx),
        .z_o    (z_nx)
    );

    // NOTE: every signal gets its hold value first, so no path through the
    // case leaves one unassigned and no latch is inferred.
    always_comb begin
        state_d = state_q;
        mode_d  = mode_q;
        i_d     = i_q;
        x_d     = x_q;
        y_d     = y_q;
        z_d     = z_q;
        unique case (state_q)
            IDLE: begin
                if (in_valid_i) begin
                    x_d     = x_i;
                    y_d     = y_i;
                    z_d     = z_i;
                    mode_d  = mode_e'(mode_i);
                    i_d     = '0;
                    state_d = RUN;
                end
            end
            RUN: begin
                x_d = x_nx;
                y_d = y_nx;
                z_d = z_nx;
                // The counter parks on its last value so it never wraps.
                if (i_q == LastI) begin
                    state_d = DONE;
                end else begin
                    i_d = i_q + CntW'(1);
                end
            end
            DONE: begin
                if (out_ready_i) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values, independent of statement order.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= IDLE;
            mode_q  <= ROTATION;
            i_q     <= '0;
            x_q     <= '0;
            y_q     <= '0;
            z_q     <= '0;
        end else begin
            state_q <= state_d;
            mode_q  <= mode_d;
            i_q     <= i_d;
            x_q     <= x_d;
            y_q     <= y_d;
            z_q     <= z_d;
        end
    end

    assign in_ready_o  = (state_q == IDLE);
    assign out_valid_o = (state_q == DONE);
    assign busy_o      = (state_q != IDLE);
    assign x_o         = x_q;
    assign y_o         = y_q;
    assign z_o         = z_q;

endmodule

// File: tb/tb_cordic_iter.sv
// Self-checking bench for cordic_iter: directed vectors, back-pressure, reset
// abort, streaming throughput against a bit-exact model, and a 12-bit/4-iter build.
module tb_cordic_iter;
    import cordic_pkg::*;

    localparam int W  = 16;
    localparam int N  = 16;
    localparam int W2 = 12;
    localparam int N2 = 4;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    logic          in_valid, in_ready, mode, out_valid, out_ready, busy;
    logic [W-1:0]  x_in, y_in, z_in, x_out, y_out, z_out;
    logic          in_valid2, in_ready2, mode2, out_valid2, out_ready2, busy2;
    logic [W2-1:0] x_in2, y_in2, z_in2, x_out2, y_out2, z_out2;

    cordic_iter #(.Width(W), .Iter(N)) dut (
        .clk_i(clk), .rst_ni(rst_n),
        .in_valid_i(in_valid), .in_ready_o(in_ready), .mode_i(mode),
        .x_i(x_in), .y_i(y_in), .z_i(z_in),
        .out_valid_o(out_valid), .out_ready_i(out_ready),
        .x_o(x_out), .y_o(y_out), .z_o(z_out), .busy_o(busy)
    );

    cordic_iter #(.Width(W2), .Iter(N2)) dut2 (
        .clk_i(clk), .rst_ni(rst_n),
        .in_valid_i(in_valid2), .in_ready_o(in_ready2), .mode_i(mode2),
        .x_i(x_in2), .y_i(y_in2), .z_i(z_in2),
        .out_valid_o(out_valid2), .out_ready_i(out_ready2),
        .x_o(x_out2), .y_o(y_out2), .z_o(z_out2), .busy_o(busy2)
    );

    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input int got, input int exp, input int tol = 0);
        int diff;
        checks++;
        diff = (got > exp) ? got - exp : exp - got;
        if (diff > tol) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d (tolerance %0d)", name, got, exp, tol);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Sign-extend the low w bits of v: models modulo-2^w two's-complement wrap.
    function automatic int wrap(input int v, input int w);
        int s;
        s = 32 - w;
        return (v <<< s) >>> s;
    endfunction

    // Reference arctangent in binary-angle units: 2^w codes per 2*pi radians.
    function automatic int ref_atan(input int i, input int w);
        return int'($floor($atan2(1.0, $pow(2.0, i)) * $pow(2.0, w) / (2.0 * 3.141592653589793) + 0.5));
    endfunction

    // Behavioural CORDIC: Iter steps of d-signed shift-add on wrapped integers.
    function automatic void model(input int w, input int it, input logic m,
                                  input int xi, input int yi, input int zi,
                                  output int xo, output int yo, output int zo);
        int x, y, z, d, xn, yn;
        x = wrap(xi, w);
        y = wrap(yi, w);
        z = wrap(zi, w);
        for (int i = 0; i < it; i++) begin
            if (m) d = (y < 0) ? 1 : -1;
            else   d = (z >= 0) ? 1 : -1;
            xn = wrap(x - d * (y >>> i), w);
            yn = wrap(y + d * (x >>> i), w);
            z  = wrap(z - d * ref_atan(i, w), w);
            x  = xn;
            y  = yn;
        end
        xo = x;
        yo = y;
        zo = z;
    endfunction

    function automatic int rnd(input int w);
        return int'($urandom_range(0, (1 << w) - 1)) - (1 << (w - 1));
    endfunction

    // Offer one operand set to the 16-bit DUT and wait (bounded) for out_valid.
    task automatic run_op(input logic m, input int xi, input int yi, input int zi,
                          output int xo, output int yo, output int zo, output int lat);
        mode     = m;
        x_in     = W'(xi);
        y_in     = W'(yi);
        z_in     = W'(zi);
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        lat = 0;
        while (!out_valid && lat < 100) begin
            tick();
            lat++;
        end
        xo = int'($signed(x_out));
        yo = int'($signed(y_out));
        zo = int'($signed(z_out));
    endtask

    task automatic consume();
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
    endtask

    typedef struct {
        logic m;
        int   x, y, z;
        int   ex, ey, ez;
        int   tolx, tol;
    } vec_t;

    vec_t vecs[5];

    initial begin
        int gx, gy, gz, mx, my, mz, lat, cnt, cyc, done, last_acc, xs, ys, zs;
        int snap_x, snap_y, snap_z;
        bit acc;
        int qx[$], qy[$], qz[$], qa[$];

        vecs[0] = '{1'b0, 19898, 0,     'h2000, 23170, 23170, 0,      4, 4};
        vecs[1] = '{1'b1, 10000, 10000, 0,      23289, 0,     'h2000, 8, 4};
        vecs[2] = '{1'b0, 10000, 0,     'h4000, 0,     16468, 0,      8, 8};
        vecs[3] = '{1'b1, 10000, 0,     0,      16468, 0,     0,      8, 8};
        vecs[4] = '{1'b0, 10000, 0,     -'h2000, 11645, -11645, 0,    8, 8};

        rst_n = 1'b0;
        {in_valid, mode, out_ready, x_in, y_in, z_in} = '0;
        {in_valid2, mode2, out_ready2, x_in2, y_in2, z_in2} = '0;
        repeat (3) tick();

        check("rst_in_ready", int'(in_ready), 1);
        check("rst_out_valid", int'(out_valid), 0);
        check("rst_busy", int'(busy), 0);
        check("rst_x", int'(x_out), 0);
        check("rst_y", int'(y_out), 0);
        check("rst_z", int'(z_out), 0);
        rst_n = 1'b1;

        // Directed vectors: tolerance against expected geometry, exact against the model.
        for (int k = 0; k < 5; k++) begin
            run_op(vecs[k].m, vecs[k].x, vecs[k].y, vecs[k].z, gx, gy, gz, lat);
            model(W, N, vecs[k].m, vecs[k].x, vecs[k].y, vecs[k].z, mx, my, mz);
            check($sformatf("vec%0d_latency", k), lat, N);
            check($sformatf("vec%0d_x", k), gx, vecs[k].ex, vecs[k].tolx);
            check($sformatf("vec%0d_y", k), gy, vecs[k].ey, vecs[k].tol);
            check($sformatf("vec%0d_z", k), gz, vecs[k].ez, vecs[k].tol);
            check($sformatf("vec%0d_model_x", k), gx, mx);
            check($sformatf("vec%0d_model_y", k), gy, my);
            check($sformatf("vec%0d_model_z", k), gz, mz);
            consume();
            check($sformatf("vec%0d_idle", k), int'(in_ready), 1);
        end

        // Back-pressure: result held for 20 cycles while in_valid pulses are ignored.
        run_op(1'b0, 1000, 2000, 'h1000, snap_x, snap_y, snap_z, lat);
        check("bp_latency", lat, N);
        for (int c = 0; c < 20; c++) begin
            in_valid = c[0];
            x_in = W'(rnd(W));
            y_in = W'(rnd(W));
            z_in = W'(rnd(W));
            tick();
            check("bp_out_valid", int'(out_valid), 1);
            check("bp_in_ready", int'(in_ready), 0);
            check("bp_x", int'($signed(x_out)), snap_x);
            check("bp_y", int'($signed(y_out)), snap_y);
            check("bp_z", int'($signed(z_out)), snap_z);
        end
        in_valid = 1'b0;
        consume();
        check("bp_release_in_ready", int'(in_ready), 1);
        check("bp_release_out_valid", int'(out_valid), 0);
        check("bp_release_busy", int'(busy), 0);
        cnt = 0;
        for (int c = 0; c < 25; c++) begin
            tick();
            if (out_valid || busy) cnt++;
        end
        check("bp_no_queued_op", cnt, 0);

        // Reset abort at RUN with i == 7.
        mode = 1'b0; x_in = W'(5000); y_in = W'(3000); z_in = W'('h1800);
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        repeat (7) tick();
        check("rst_run_busy_before", int'(busy), 1);
        rst_n = 1'b0;
        #1;
        check("rst_run_out_valid", int'(out_valid), 0);
        check("rst_run_in_ready", int'(in_ready), 1);
        check("rst_run_busy", int'(busy), 0);
        check("rst_run_x", int'(x_out), 0);
        check("rst_run_y", int'(y_out), 0);
        check("rst_run_z", int'(z_out), 0);
        tick();
        rst_n = 1'b1;
        cnt = 0;
        for (int c = 0; c < 30; c++) begin
            tick();
            if (out_valid) cnt++;
        end
        check("rst_run_no_stale", cnt, 0);

        // Reset in DONE, then accept on the first edge after release.
        run_op(1'b1, 8000, -3000, 0, gx, gy, gz, lat);
        check("rst_done_reached", int'(out_valid), 1);
        rst_n = 1'b0;
        #1;
        check("rst_done_out_valid", int'(out_valid), 0);
        check("rst_done_x", int'(x_out), 0);
        tick();
        rst_n = 1'b1;
        run_op(1'b0, 12000, -4000, -'h0C00, gx, gy, gz, lat);
        model(W, N, 1'b0, 12000, -4000, -'h0C00, mx, my, mz);
        check("first_accept_latency", lat, N);
        check("first_accept_x", gx, mx);
        check("first_accept_y", gy, my);
        check("first_accept_z", gz, mz);
        consume();

        // Streaming: both handshakes tied high, 1000 random rotations.
        in_valid = 1'b1; out_ready = 1'b1; mode = 1'b0;
        xs = rnd(W); ys = rnd(W); zs = rnd(W);
        x_in = W'(xs); y_in = W'(ys); z_in = W'(zs);
        last_acc = -1; cyc = 0; done = 0;
        while (done < 1000 && cyc < 20000) begin
            acc = 1'b0;
            if (in_ready) begin
                qx.push_back(xs); qy.push_back(ys); qz.push_back(zs); qa.push_back(cyc + 1);
                if (last_acc >= 0) check("stream_interval", cyc + 1 - last_acc, N + 2);
                last_acc = cyc + 1;
                acc = 1'b1;
            end
            tick();
            cyc++;
            if (acc) begin
                xs = rnd(W); ys = rnd(W); zs = rnd(W);
                x_in = W'(xs); y_in = W'(ys); z_in = W'(zs);
            end
            if (out_valid) begin
                check("stream_pending", int'(qx.size() > 0), 1);
                if (qx.size() > 0) begin
                    model(W, N, 1'b0, qx.pop_front(), qy.pop_front(), qz.pop_front(), mx, my, mz);
                    check("stream_latency", cyc - qa.pop_front(), N);
                    check("stream_x", int'($signed(x_out)), mx);
                    check("stream_y", int'($signed(y_out)), my);
                    check("stream_z", int'($signed(z_out)), mz);
                end
                done++;
            end
        end
        check("stream_count", done, 1000);
        in_valid = 1'b0;
        repeat (N + 4) tick();
        out_ready = 1'b0;

        // Width=12, Iter=4 build: LUT formula, latency, bit-exact stream.
        for (int i = 0; i < N2; i++) check($sformatf("lut12_%0d", i), atan_lut(i, W2), ref_atan(i, W2));
        for (int i = 0; i < N; i++) check($sformatf("lut16_%0d", i), atan_lut(i, W), ref_atan(i, W));
        check("lut12_0_const", atan_lut(0, W2), 512);
        check("lut16_0_const", atan_lut(0, W), 'h2000);
        check("w12_reset_in_ready", int'(in_ready2), 1);

        in_valid2 = 1'b1; out_ready2 = 1'b1; mode2 = 1'b0;
        xs = rnd(W2); ys = rnd(W2); zs = rnd(W2);
        x_in2 = W2'(xs); y_in2 = W2'(ys); z_in2 = W2'(zs);
        qx.delete(); qy.delete(); qz.delete(); qa.delete();
        last_acc = -1; cyc = 0; done = 0;
        while (done < 200 && cyc < 2000) begin
            acc = 1'b0;
            if (in_ready2) begin
                qx.push_back(xs); qy.push_back(ys); qz.push_back(zs); qa.push_back(cyc + 1);
                if (last_acc >= 0) check("w12_interval", cyc + 1 - last_acc, N2 + 2);
                last_acc = cyc + 1;
                acc = 1'b1;
            end
            tick();
            cyc++;
            if (acc) begin
                xs = rnd(W2); ys = rnd(W2); zs = rnd(W2);
                x_in2 = W2'(xs); y_in2 = W2'(ys); z_in2 = W2'(zs);
            end
            if (out_valid2) begin
                check("w12_pending", int'(qx.size() > 0), 1);
                if (qx.size() > 0) begin
                    model(W2, N2, 1'b0, qx.pop_front(), qy.pop_front(), qz.pop_front(), mx, my, mz);
                    check("w12_latency", cyc - qa.pop_front(), N2);
                    check("w12_x", int'($signed(x_out2)), mx);
                    check("w12_y", int'($signed(y_out2)), my);
                    check("w12_z", int'($signed(z_out2)), mz);
                end
                done++;
            end
        end
        check("w12_count", done, 200);
        in_valid2 = 1'b0;
        repeat (N2 + 4) tick();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation exceeded its time limit");
        $fatal(1);
    end

endmodule

// File: doc/cordic_iter.md
CORDIC_ITER -- requirements
Module: cordic_iter

Interface
REQ-001 The module SHALL have parameter Width, default 16, meaning the signed two's-complement width of x, y and z.
REQ-002 The module SHALL have parameter Iter, default 16, meaning the number of micro-rotations (legal 1..Width).
REQ-003 The module SHALL have port clk_i, input, 1 bit: clock; all state updates on the rising edge.
REQ-004 The module SHALL have port rst_ni, input, 1 bit: reset, asynchronous, active-low.
REQ-005 The module SHALL have port in_valid_i, input, 1 bit: an operand set is offered.
REQ-006 The module SHALL have port in_ready_o, output, 1 bit: the block accepts an operand set.
REQ-007 The module SHALL have port mode_i, input, 1 bit: 0 = rotation, 1 = vectoring.
REQ-008 The module SHALL have ports x_i, y_i and z_i, input, Width bits each: initial vector and angle.
REQ-009 The module SHALL have port out_valid_o, output, 1 bit: a result is presented.
REQ-010 The module SHALL have port out_ready_i, input, 1 bit: the consumer takes the result.
REQ-011 The module SHALL have ports x_o, y_o and z_o, output, Width bits each: result registers.
REQ-012 The module SHALL have port busy_o, output, 1 bit: high in any state except IDLE.

Function
REQ-013 The FSM SHALL use states IDLE, RUN and DONE; in_ready_o = (state==IDLE); out_valid_o = (state==DONE).
REQ-014 On accept (IDLE, in_valid_i=1), the block SHALL:
- load x, y, z and mode;
- clear iteration counter i to 0;
- go to RUN.
REQ-015 Each RUN cycle SHALL perform one micro-rotation and then increment i.
REQ-016 The direction d SHALL be:
- rotation: d=+1 if z>=0, else -1;
- vectoring: d=+1 if y<0, else -1.
REQ-017 The micro-rotation update SHALL be:
- x' = x - d*(y>>>i);
- y' = y + d*(x>>>i);
- z' = z - d*atan_lut[i].
Shifts are arithmetic; sums wrap modulo 2^Width with no saturation.
REQ-018 The angle format SHALL be a binary angle: full circle = 2^Width; 0x4000 = 90 deg at Width=16.
REQ-019 atan_lut[i] SHALL equal round(atan(2^-i) * 2^(Width-1) / pi), computed at elaboration.
REQ-020 On the RUN cycle with i==Iter-1, the FSM SHALL go to DONE; out_valid_o rises exactly Iter cycles after the accept edge.
REQ-021 The CORDIC gain (~1.6468 for Iter>=8) SHALL NOT be compensated; the caller prescales.
REQ-022 In DONE, x_o, y_o and z_o SHALL hold stable until out_ready_i=1; that edge returns the FSM to IDLE.
REQ-023 in_valid_i during RUN or DONE SHALL be ignored, with no queuing.
REQ-024 Minimum initiation interval SHALL be Iter+2 cycles when out_ready_i is tied high.
REQ-025 Convergence SHALL be guaranteed only for |z| <= ~99.7 deg (rotation) and x>0 (vectoring); results outside that range are unspecified but deterministic.
REQ-026 The iteration counter width SHALL be $clog2(Iter) (minimum 1) and SHALL never wrap within an operation.

Reset
REQ-027 While rst_ni=0, the block SHALL force:
- state = IDLE, i = 0;
- x, y, z and mode registers = 0;
- in_ready_o=1, out_valid_o=0, busy_o=0;
- x_o, y_o, z_o = 0.
REQ-028 Reset asserted mid-RUN or in DONE SHALL abort the operation without emitting a result.
REQ-029 The first accept SHALL be possible on the first rising edge after rst_ni deasserts.

Structure
REQ-030 Package cordic_pkg SHALL hold:
- the state enum (IDLE/RUN/DONE);
- the mode enum (ROTATION/VECTORING);
- the elaboration-time atan_lut function of (i, Width).
REQ-031 One combinational sub-module, cordic_stage, SHALL implement one micro-rotation (inputs x, y, z, i, d, atan; outputs x', y', z'). The FSM, counter and registers SHALL be inline.

Verification
REQ-032 Rotation test: Width=16, Iter=16, x=19898, y=0, z=0x2000 -> after 16 cycles x_o ~ y_o ~ 23170 (+/-4), z_o ~ 0 (+/-4).
REQ-033 Vectoring test: x=10000, y=10000, z=0 -> x_o ~ 23289 (+/-8), y_o ~ 0 (+/-4), z_o ~ 0x2000 (+/-4).
REQ-034 Back-pressure test: out_ready_i=0 for 20 cycles after out_valid_o -> outputs stable; in_valid_i pulses ignored; out_ready_i=1 -> IDLE next edge.
REQ-035 Reset test: rst_ni low at RUN i=7 -> immediately out_valid_o=0, in_ready_o=1, outputs 0; no stale result appears later.
REQ-036 Throughput test: in_valid_i and out_ready_i tied high -> accepts exactly every 18 cycles; 1000 random rotation operands match a bit-exact model.
REQ-037 Parameter test: Width=12, Iter=4 -> latency 4 cycles; the LUT matches the formula; the bit-exact model agrees.
